// File: rtl/instruction_fetch_unit_pkg.sv
// Shared pipeline definitions: fetch FSM states, NOP encoding, PC step and
// word-alignment helper used by the fetch stage and the stage registers.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction memory handshake, hazard/branch controls from
// later stages, and the IF/ID register contents presented to decode.
interface instruction_fetch_unit_if;

    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_pc4;
    logic        IF_ID_valid;
    logic        fetch_busy;

    modport master (
        output imem_addr, imem_req, IF_ID_instr, IF_ID_pc4, IF_ID_valid, fetch_busy,
        input  imem_rdata, imem_ack, stall, branch_taken, branch_target
    );

    modport slave (
        input  imem_addr, imem_req, IF_ID_instr, IF_ID_pc4, IF_ID_valid, fetch_busy,
        output imem_rdata, imem_ack, stall, branch_taken, branch_target
    );

endinterface

// File: rtl/if_id_register.sv
// Pipeline stage register carrying instruction, pc+4 and valid. Flush forces
// a NOP bubble and wins over load; with neither asserted the contents hold.
module if_id_register
    import instruction_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, runs the IDLE/REQ/HOLD request FSM, parks a word
// fetched during a stall in a one-entry buffer, and redirects on branches.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_hold_instr;
    logic         r_hold_valid;

    logic         w_req;
    logic         w_ack;
    logic [31:0]  w_pc_inc;
    logic         w_load_mem;
    logic         w_load_hold;
    logic         w_flush;
    logic [31:0]  w_load_instr;
    logic [31:0]  w_load_pc4;

    assign w_req    = (r_state == REQ);
    assign w_ack    = w_req & bus.imem_ack;
    assign w_pc_inc = r_pc + PC_INC;

    assign w_load_mem  = w_ack & ~bus.stall;
    assign w_load_hold = (r_state == HOLD) & r_hold_valid & ~bus.stall;

    // Bubble whenever decode is free to advance but no word arrives this edge.
    assign w_flush = bus.branch_taken
                   | ((r_state == IDLE) & ~bus.stall)
                   | (w_req & ~bus.imem_ack & ~bus.stall);

    // The PC already advanced when the buffered word was captured, so it is pc+4.
    assign w_load_instr = w_load_hold ? r_hold_instr : bus.imem_rdata;
    assign w_load_pc4   = w_load_hold ? r_pc         : w_pc_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_pc         <= word_align(RESET_PC);
            r_hold_instr <= NOP_INSTR;
            r_hold_valid <= 1'b0;
        end else if (bus.branch_taken) begin
            r_state      <= IDLE;
            r_pc         <= word_align(bus.branch_target);
            r_hold_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: r_state <= REQ;
                REQ: begin
                    if (w_ack) begin
                        r_pc <= w_pc_inc;
                        if (bus.stall) begin
                            r_hold_instr <= bus.imem_rdata;
                            r_hold_valid <= 1'b1;
                            r_state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!bus.stall) begin
                        r_hold_valid <= 1'b0;
                        r_state      <= REQ;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.imem_addr  = r_pc;
    assign bus.imem_req   = w_req;
    assign bus.fetch_busy = w_req & ~bus.imem_ack;

    if_id_register u_if_id (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load_mem | w_load_hold),
        .i_flush (w_flush),
        .i_instr (w_load_instr),
        .i_pc4   (w_load_pc4),
        .o_instr (bus.IF_ID_instr),
        .o_pc4   (bus.IF_ID_pc4),
        .o_valid (bus.IF_ID_valid)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for the fetch stage: a memory model answers requests with
// address-tagged words; a monitor scoreboards every newly loaded IF/ID entry.
module tb_instruction_fetch_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   ws    = 0;
    int   cnt   = 0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] a);
        exp_t e;
        e.instr = word(a);
        e.pc4   = a + 32'd4;
        exp_q.push_back(e);
    endtask

    // Memory answers after ws idle request cycles; inputs settle before the edge.
    task automatic mem_drive();
        if (bus.imem_req && !reset) begin
            if (cnt == ws) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = word(bus.imem_addr);
                cnt = 0;
            end else begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = 32'hDEAD_BEEF;
                cnt++;
            end
        end else begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = 32'hDEAD_BEEF;
            cnt = 0;
        end
        #1;
    endtask

    task automatic cycle();
        mem_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr"}, bus.IF_ID_instr, 32'h0);
        check({tag, "_pc4"},   bus.IF_ID_pc4,   32'h0);
        check({tag, "_valid"}, 32'(bus.IF_ID_valid), 32'd0);
        check({tag, "_req"},   32'(bus.imem_req),    32'd0);
        check({tag, "_busy"},  32'(bus.fetch_busy),  32'd0);
        check({tag, "_addr"},  bus.imem_addr,  32'h0);
    endtask

    // Monitor: a new IF/ID entry is a valid word whose pc4 differs from the last one.
    initial begin
        logic        pv;
        logic [31:0] ppc;
        exp_t        e;
        pv  = 1'b0;
        ppc = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.IF_ID_valid === 1'b1 && (!pv || bus.IF_ID_pc4 !== ppc)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected: got instr %h pc4 %h, expected none",
                             bus.IF_ID_instr, bus.IF_ID_pc4);
                end else begin
                    e = exp_q.pop_front();
                    $display("IF_ID load: instr %h pc4 %h (expected %h %h)",
                             bus.IF_ID_instr, bus.IF_ID_pc4, e.instr, e.pc4);
                    check("sb_instr", bus.IF_ID_instr, e.instr);
                    check("sb_pc4",   bus.IF_ID_pc4,   e.pc4);
                end
            end
            pv  = bus.IF_ID_valid;
            ppc = bus.IF_ID_pc4;
        end
    end

    initial begin
        reset             = 1'b1;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        bus.imem_ack      = 1'b0;
        bus.imem_rdata    = 32'h0;
        cycle();
        cycle();
        check_reset_outputs("rst");

        // Zero-wait streaming: first word at edge 2, then one per edge.
        ws = 0;
        push(32'h0); push(32'h4); push(32'h8); push(32'hC);
        reset = 1'b0;
        cycle();
        check("p1_req",  32'(bus.imem_req), 32'd1);
        check("p1_addr", bus.imem_addr, 32'h0);
        repeat (4) cycle();
        reset = 1'b1;
        cycle();

        // Two wait states: valid words every third edge, bubbles between.
        ws = 2;
        push(32'h0); push(32'h4); push(32'h8);
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            mem_drive();
            check($sformatf("p2_busy_%0d", k), 32'(bus.fetch_busy), 32'((k % 3) != 1));
            @(posedge clk);
            #1;
            if (k >= 2) begin
                check($sformatf("p2_valid_%0d", k), 32'(bus.IF_ID_valid), 32'((k % 3) == 1));
                if ((k % 3) != 1)
                    check($sformatf("p2_bubble_%0d", k), bus.IF_ID_instr, 32'h0);
            end
        end
        reset = 1'b1;
        cycle();

        // Stall coincident with the ack of word@8, held for three edges.
        ws = 0;
        push(32'h0); push(32'h4); push(32'h8); push(32'hC);
        reset = 1'b0;
        repeat (3) cycle();
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check($sformatf("p3_req_%0d", k),   32'(bus.imem_req), 32'd0);
            check($sformatf("p3_instr_%0d", k), bus.IF_ID_instr, word(32'h4));
            check($sformatf("p3_addr_%0d", k),  bus.imem_addr, 32'hC);
        end
        bus.stall = 1'b0;
        cycle();
        check("p3_req_rel",  32'(bus.imem_req), 32'd1);
        check("p3_addr_rel", bus.imem_addr, 32'hC);
        cycle();
        reset = 1'b1;
        cycle();

        // Branch together with ack and stall: data dropped, redirect to 0x100.
        push(32'h0); push(32'h4); push(32'h100); push(32'h104);
        reset = 1'b0;
        repeat (3) cycle();
        bus.stall         = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0103;
        cycle();
        bus.stall        = 1'b0;
        bus.branch_taken = 1'b0;
        check("p4_valid", 32'(bus.IF_ID_valid), 32'd0);
        check("p4_instr", bus.IF_ID_instr, 32'h0);
        check("p4_req",   32'(bus.imem_req), 32'd0);
        check("p4_addr",  bus.imem_addr, 32'h100);
        cycle();
        check("p4_nop2", 32'(bus.IF_ID_valid), 32'd0);
        cycle();
        check("p4_tgt", bus.IF_ID_instr, word(32'h100));
        cycle();
        reset = 1'b1;
        cycle();

        // PC wrap at the top of the address space.
        push(32'hFFFF_FFFC); push(32'h0);
        reset = 1'b0;
        cycle();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'hFFFF_FFFC;
        cycle();
        bus.branch_taken = 1'b0;
        cycle();
        check("p5_addr", bus.imem_addr, 32'hFFFF_FFFC);
        cycle();
        check("p5_pc4",  bus.IF_ID_pc4, 32'h0);
        check("p5_next", bus.imem_addr, 32'h0);
        cycle();
        reset = 1'b1;
        cycle();

        // Reset while parked in HOLD with stall still asserted.
        push(32'h0);
        reset = 1'b0;
        repeat (2) cycle();
        bus.stall = 1'b1;
        cycle();
        check("p6_hold_req", 32'(bus.imem_req), 32'd0);
        reset = 1'b1;
        cycle();
        check_reset_outputs("p6_rst");
        push(32'h0);
        reset     = 1'b0;
        bus.stall = 1'b0;
        cycle();
        check("p6_idle_valid", 32'(bus.IF_ID_valid), 32'd0);
        cycle();
        check("p6_instr", bus.IF_ID_instr, word(32'h0));
        check("p6_pc4",   bus.IF_ID_pc4, 32'h4);
        reset = 1'b1;
        cycle();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the 5-stage ARM pipeline: owns the PC, issues word fetches to instruction memory over a req/ack handshake, and loads the IF/ID pipeline register whose instruction word drives the ID-stage control unit. Handles hazard stalls with a one-entry hold buffer, and branch redirects with an IF/ID flush to the all-zero NOP.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- clk  in  1  pipeline clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- imem_addr  out  32  fetch address, always the current PC; stable while imem_req=1 and no ack.
- imem_req  out  1  fetch request; a transfer completes on any cycle with imem_req=1 and imem_ack=1.
- imem_rdata  in  32  instruction word, valid only in the ack cycle.
- imem_ack  in  1  memory completion; ignored when imem_req=0.
- stall  in  1  hazard unit: hold IF/ID and the PC.
- branch_taken  in  1  ID stage: redirect fetch; priority over stall.
- branch_target  in  32  redirect address; bits [1:0] forced to 0 internally.
- IF_ID_instr  out  32  instruction to the ID stage; 32'h0 is the NOP.
- IF_ID_pc4  out  32  address of IF_ID_instr + 4.
- IF_ID_valid  out  1  1 = IF_ID_instr is a real fetched instruction.
- fetch_busy  out  1  1 = request outstanding, no ack this cycle.

## Operation
- Reset values: PC=RESET_PC, state=IDLE, IF_ID_instr=0, IF_ID_pc4=0, IF_ID_valid=0, hold buffer empty, imem_req=0, fetch_busy=0.
- States: IDLE, REQ, HOLD. imem_req=1 only in REQ. fetch_busy = (state==REQ) & ~imem_ack.
- IDLE: IF_ID loads NOP/valid=0 unless stall; next state REQ.
- REQ, ack, ~stall: IF_ID_instr<=imem_rdata, IF_ID_pc4<=PC+4, IF_ID_valid<=1, PC<=PC+4; stay REQ (back-to-back fetch at new PC).
- REQ, ack, stall: imem_rdata into hold buffer, PC<=PC+4, IF_ID unchanged; -> HOLD.
- REQ, ~ack, ~stall: IF_ID loads bubble (instr=0, valid=0); PC unchanged; stay REQ.
- REQ, ~ack, stall: IF_ID and PC unchanged; stay REQ.
- HOLD, stall: everything held. HOLD, ~stall: IF_ID loads buffer (pc4 = current PC), valid=1; buffer emptied; -> REQ.
- branch_taken (any state, not reset): PC<=branch_target&~3, IF_ID flushed to NOP/valid=0, hold buffer emptied, any same-cycle ack data discarded, state -> IDLE (request cancelled by req dropping for one cycle).
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.
- reset mid-operation (any state, any input combination) reproduces the reset values on the next edge; reset beats branch_taken and stall.

## Timing
- Zero-wait memory (ack in the req cycle): first instruction in IF_ID 2 edges after reset falls (IDLE, REQ); thereafter one instruction per cycle.
- N wait states add N bubbles (valid=0) per instruction when not stalled.
- Branch penalty: branch edge -> IDLE -> REQ; target instruction in IF_ID 2 edges after the branch edge with zero-wait memory; IF_ID shows NOP for those cycles.
- Stall release from HOLD: buffered instruction appears on the first edge with stall=0; no refetch.
- imem_addr changes only on edges where ack was seen, a branch was taken, or reset asserted.

## Structure
- Shared pipeline package: fetch state enum (IDLE/REQ/HOLD), NOP_INSTR = 32'h0, PC_INC = 32'd4.
- One sub-module: if_id_register (instr, pc4, valid; load/flush/hold controls, flush wins), reused pattern for later stage registers. FSM, PC, hold buffer stay in the top.

## Test plan
- Reset release, RESET_PC=0, zero-wait memory returning addr-tagged words -> IF_ID_instr at edge 2 is word@0, pc4=4; then @4, @8 on consecutive edges, valid=1.
- 2 wait states per fetch -> each valid instruction separated by exactly 2 bubbles with IF_ID_instr=0, valid=0; fetch_busy high in wait cycles.
- stall held 3 cycles coincident with ack of word@8 -> IF_ID holds word@4, state HOLD, req=0; on release word@8 loads with pc4=12, next fetch at 12.
- branch_taken with target 32'h0000_0103 in same cycle as ack and stall -> ack data dropped, IF_ID=NOP/valid=0, next imem_addr=0x100, word@0x100 in IF_ID 2 edges later.
- PC=32'hFFFF_FFFC fetched -> IF_ID_pc4=0, next imem_addr=0.
- reset asserted while in HOLD with stall=1 -> next edge all outputs at reset values, buffer empty, PC=RESET_PC.
